// File: rtl/cu_pkg.sv
// Shared types and constants for the hardwired control sequencer: states, opcodes,
// ALU encodings, instruction field positions and the registered strobe bundle.
package cu_pkg;

    localparam int unsigned IR_W  = 32;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned REG_W = 4;
    localparam int unsigned ALU_W = 5;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;

    typedef enum logic [2:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_HALT
    } cu_state_e;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11000;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11001;

    // ALU operations share the R-type opcode encoding
    localparam logic [ALU_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(OP_ADD);
    localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(OP_AND);
    localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(OP_OR);

    typedef struct packed {
        logic              pc_out;
        logic              mar_in;
        logic              inc_pc;
        logic              z_in;
        logic              zlo_out;
        logic              pc_in;
        logic              read;
        logic              mdr_in;
        logic              mdr_out;
        logic              ir_in;
        logic              y_in;
        logic              c_out;
        logic              gra;
        logic              grb;
        logic              grc;
        logic              r_in;
        logic              r_out;
        logic [ALU_W-1:0]  alu_op;
        logic              run;
    } cu_strobe_t;

endpackage

// File: rtl/control_unit_ir_decode.sv
// Combinational opcode classifier; any opcode that is not R/I-type or HALT reports as NOP.
module ir_decode
    import cu_pkg::*;
(
    input  logic [OP_W-1:0]  opcode,
    output logic             is_rtype_c,
    output logic             is_itype_c,
    output logic             is_halt_c,
    output logic             is_nop_c,
    output logic [ALU_W-1:0] alu_op_c
);

    always_comb begin
        is_rtype_c = 1'b0;
        is_itype_c = 1'b0;
        is_halt_c  = 1'b0;
        alu_op_c   = ALU_NONE;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
                is_rtype_c = 1'b1;
                alu_op_c   = ALU_W'(opcode);
            end
            OP_ADDI: begin
                is_itype_c = 1'b1;
                alu_op_c   = ALU_ADD;
            end
            OP_ANDI: begin
                is_itype_c = 1'b1;
                alu_op_c   = ALU_AND;
            end
            OP_ORI: begin
                is_itype_c = 1'b1;
                alu_op_c   = ALU_OR;
            end
            OP_HALT: is_halt_c = 1'b1;
            default: ;
        endcase
    end

    assign is_nop_c = ~(is_rtype_c | is_itype_c | is_halt_c);

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the datapath strobes.
// Optional T1 memory wait on Mem_ready is enabled by defining CU_MEM_WAIT_EN.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned OPW  = OP_W,
    parameter int unsigned REGW = REG_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [IR_W-1:0]   IR,
    input  logic              Mem_ready,
    input  logic              Stop,
    output logic              PCout,
    output logic              MARin,
    output logic              IncPC,
    output logic              Zin,
    output logic              ZLOout,
    output logic              PCin,
    output logic              Read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Cout,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic [ALU_W-1:0]  Alu_op,
    output logic              Run
);

    localparam int unsigned FIELD_LSB = IR_W - OPW - 3 * REGW;

    cu_state_e        state_q, state_d;
    cu_strobe_t       strobe_q, strobe_d;
    logic             is_rtype, is_itype, is_halt, is_nop;
    logic [ALU_W-1:0] dec_alu_op;
    logic             ir_fields_unused;

    ir_decode u_ir_decode (
        .opcode     (OP_W'(IR[IR_W-1 -: OPW])),
        .is_rtype_c (is_rtype),
        .is_itype_c (is_itype),
        .is_halt_c  (is_halt),
        .is_nop_c   (is_nop),
        .alu_op_c   (dec_alu_op)
    );

    // Register operand fields are routed to the register file by the datapath, not here
`ifdef CU_MEM_WAIT_EN
    assign ir_fields_unused = ^{IR[IR_W-OPW-1:FIELD_LSB], IR[FIELD_LSB-1:0]};
`else
    assign ir_fields_unused = ^{IR[IR_W-OPW-1:FIELD_LSB], IR[FIELD_LSB-1:0], Mem_ready};
`endif

    // State and output registers; async reset aborts any instruction in flight
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_RST;
            strobe_q     <= '0;
            strobe_q.run <= 1'b1;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
        end
    end

    // Next state, then outputs decoded from the state being entered
    always_comb begin
        state_d      = state_q;
        strobe_d     = '0;
        strobe_d.run = 1'b1;

        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
`ifdef CU_MEM_WAIT_EN
            ST_T1:  if (Mem_ready) state_d = ST_T2;
`else
            ST_T1:  state_d = ST_T2;
`endif
            ST_T2: begin
                if (is_halt || (is_nop && Stop)) state_d = ST_HALT;
                else if (is_nop)                 state_d = ST_T0;
                else                             state_d = ST_T3;
            end
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = Stop ? ST_HALT : ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase

        case (state_d)
            ST_T0: begin
                strobe_d.pc_out = 1'b1;
                strobe_d.mar_in = 1'b1;
                strobe_d.inc_pc = 1'b1;
                strobe_d.z_in   = 1'b1;
            end
            ST_T1: begin
                strobe_d.zlo_out = 1'b1;
                strobe_d.pc_in   = 1'b1;
                strobe_d.read    = 1'b1;
                strobe_d.mdr_in  = 1'b1;
            end
            ST_T2: begin
                strobe_d.mdr_out = 1'b1;
                strobe_d.ir_in   = 1'b1;
            end
            ST_T3: begin
                strobe_d.grb   = 1'b1;
                strobe_d.r_out = 1'b1;
                strobe_d.y_in  = 1'b1;
            end
            ST_T4: begin
                strobe_d.z_in   = 1'b1;
                strobe_d.alu_op = dec_alu_op;
                if (is_itype) begin
                    strobe_d.c_out = 1'b1;
                end else begin
                    strobe_d.grc   = 1'b1;
                    strobe_d.r_out = 1'b1;
                end
            end
            ST_T5: begin
                strobe_d.zlo_out = 1'b1;
                strobe_d.gra     = 1'b1;
                strobe_d.r_in    = 1'b1;
            end
            ST_HALT: strobe_d.run = 1'b0;
            default: ;
        endcase
    end

    assign PCout  = strobe_q.pc_out;
    assign MARin  = strobe_q.mar_in;
    assign IncPC  = strobe_q.inc_pc;
    assign Zin    = strobe_q.z_in;
    assign ZLOout = strobe_q.zlo_out;
    assign PCin   = strobe_q.pc_in;
    assign Read   = strobe_q.read;
    assign MDRin  = strobe_q.mdr_in;
    assign MDRout = strobe_q.mdr_out;
    assign IRin   = strobe_q.ir_in;
    assign Yin    = strobe_q.y_in;
    assign Cout   = strobe_q.c_out;
    assign Gra    = strobe_q.gra;
    assign Grb    = strobe_q.grb;
    assign Grc    = strobe_q.grc;
    assign Rin    = strobe_q.r_in;
    assign Rout   = strobe_q.r_out;
    assign Alu_op = strobe_q.alu_op;
    assign Run    = strobe_q.run;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; honours CU_MEM_WAIT_EN when defined.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        Mem_ready = 1'b1;
    logic        Stop = 1'b0;
    logic        PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Cout, Gra, Grb, Grc, Rin, Rout, Run;
    logic [4:0]  Alu_op;

    int tests = 0;
    int fails = 0;

    // Strobe vector order: PCout MARin IncPC Zin ZLOout PCin Read MDRin MDRout IRin Yin Cout Gra Grb Grc Rin Rout
    logic [16:0] obs;
    assign obs = {PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin,
                  Yin, Cout, Gra, Grb, Grc, Rin, Rout};

    localparam logic [16:0] S_NONE = 17'h00000;
    localparam logic [16:0] S_T0   = 17'h1E000;
    localparam logic [16:0] S_T1   = 17'h01E00;
    localparam logic [16:0] S_T2   = 17'h00180;
    localparam logic [16:0] S_T3   = 17'h00049;
    localparam logic [16:0] S_T4R  = 17'h02005;
    localparam logic [16:0] S_T4I  = 17'h02020;
    localparam logic [16:0] S_T5   = 17'h01012;

    always #5 Clock = ~Clock;

    control_unit dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .IR        (IR),
        .Mem_ready (Mem_ready),
        .Stop      (Stop),
        .PCout     (PCout),
        .MARin     (MARin),
        .IncPC     (IncPC),
        .Zin       (Zin),
        .ZLOout    (ZLOout),
        .PCin      (PCin),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .Cout      (Cout),
        .Gra       (Gra),
        .Grb       (Grb),
        .Grc       (Grc),
        .Rin       (Rin),
        .Rout      (Rout),
        .Alu_op    (Alu_op),
        .Run       (Run)
    );

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Leaves the DUT in RST at a falling edge; the next rising edge enters T0
    task automatic do_reset(input logic [31:0] ir);
        Reset_n   = 1'b0;
        IR        = ir;
        Stop      = 1'b0;
        Mem_ready = 1'b1;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [16:0] exp_s [5];
        exp_s[0] = S_T0; exp_s[1] = S_T1; exp_s[2] = S_T2; exp_s[3] = S_T0; exp_s[4] = S_T1;
        Reset_n = 1'b0;
        IR      = 32'h0;
        tick();
        tests++;
        if (obs !== S_NONE) begin
            fails++; $display("FAIL reset_strobes got %h want %h", obs, S_NONE);
        end
        tests++;
        if (Run !== 1'b1) begin
            fails++; $display("FAIL reset_run got %b want 1", Run);
        end
        tests++;
        if (Alu_op !== 5'b0) begin
            fails++; $display("FAIL reset_alu got %b want 00000", Alu_op);
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (obs !== exp_s[i] || Run !== 1'b1 || Alu_op !== 5'b0) begin
                fails++;
                $display("FAIL illegal_loop[%0d] got %h run %b alu %b want %h run 1 alu 00000",
                         i, obs, Run, Alu_op, exp_s[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [16:0] exp_s [7];
        logic [4:0]  exp_a [7];
        exp_s[0] = S_T0; exp_s[1] = S_T1; exp_s[2] = S_T2; exp_s[3] = S_T3;
        exp_s[4] = S_T4R; exp_s[5] = S_T5; exp_s[6] = S_T0;
        for (int i = 0; i < 7; i++) exp_a[i] = 5'b0;
        exp_a[4] = 5'b01010;
        do_reset(32'h50918000);
        for (int i = 0; i < 7; i++) begin
            tick();
            tests++;
            if (obs !== exp_s[i] || Alu_op !== exp_a[i] || Run !== 1'b1) begin
                fails++;
                $display("FAIL rtype_and[%0d] got %h alu %b run %b want %h alu %b run 1",
                         i, obs, Alu_op, Run, exp_s[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_itype();
        logic [31:0] irs  [3];
        logic [4:0]  alus [3];
        irs[0] = 32'h60000000; alus[0] = 5'b00011;
        irs[1] = 32'h68000000; alus[1] = 5'b01010;
        irs[2] = 32'h70000000; alus[2] = 5'b01011;
        for (int k = 0; k < 3; k++) begin
            do_reset(irs[k]);
            for (int i = 0; i < 4; i++) tick();
            tests++;
            if (obs !== S_T3) begin
                fails++; $display("FAIL itype_t3[%0d] got %h want %h", k, obs, S_T3);
            end
            tick();
            tests++;
            if (obs !== S_T4I || Alu_op !== alus[k]) begin
                fails++;
                $display("FAIL itype_t4[%0d] got %h alu %b want %h alu %b",
                         k, obs, Alu_op, S_T4I, alus[k]);
            end
            tick();
            tests++;
            if (obs !== S_T5 || Alu_op !== 5'b0) begin
                fails++; $display("FAIL itype_t5[%0d] got %h alu %b want %h alu 00000",
                                  k, obs, Alu_op, S_T5);
            end
        end
    endtask

    task automatic test_stop_t5();
        do_reset(32'h18000000);
        for (int i = 0; i < 6; i++) tick();
        tests++;
        if (obs !== S_T5) begin
            fails++; $display("FAIL stop_pre_t5 got %h want %h", obs, S_T5);
        end
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (obs !== S_NONE || Run !== 1'b0 || Alu_op !== 5'b0) begin
                fails++;
                $display("FAIL halt_hold[%0d] got %h run %b alu %b want %h run 0 alu 00000",
                         i, obs, Run, Alu_op, S_NONE);
            end
            tick();
        end
    endtask

    task automatic test_halt_opcode();
        do_reset(32'hC8000000);
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (obs !== S_T2 || Run !== 1'b1) begin
            fails++; $display("FAIL halt_op_t2 got %h run %b want %h run 1", obs, Run, S_T2);
        end
        tick();
        tests++;
        if (obs !== S_NONE || Run !== 1'b0) begin
            fails++; $display("FAIL halt_op got %h run %b want %h run 0", obs, Run, S_NONE);
        end
        tick();
        tests++;
        if (Run !== 1'b0) begin
            fails++; $display("FAIL halt_op_stay run %b want 0", Run);
        end
    endtask

    // Stop is ignored in T0/T1 and honoured at the NOP T2 boundary
    task automatic test_stop_nop();
        logic [16:0] exp_s [4];
        logic        exp_r [4];
        exp_s[0] = S_T0; exp_s[1] = S_T1; exp_s[2] = S_T2; exp_s[3] = S_NONE;
        exp_r[0] = 1'b1; exp_r[1] = 1'b1; exp_r[2] = 1'b1; exp_r[3] = 1'b0;
        do_reset(32'hC0000000);
        Stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (obs !== exp_s[i] || Run !== exp_r[i]) begin
                fails++;
                $display("FAIL stop_nop[%0d] got %h run %b want %h run %b",
                         i, obs, Run, exp_s[i], exp_r[i]);
            end
        end
        Stop = 1'b0;
    endtask

    task automatic test_mem_wait();
        do_reset(32'h0);
        tick();
        Mem_ready = 1'b0;
`ifdef CU_MEM_WAIT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (obs !== S_T1 || Read !== 1'b1) begin
                fails++; $display("FAIL mem_wait_t1[%0d] got %h read %b want %h read 1",
                                  i, obs, Read, S_T1);
            end
            if (i == 3) Mem_ready = 1'b1;
        end
`else
        tick();
        tests++;
        if (obs !== S_T1) begin
            fails++; $display("FAIL nowait_t1 got %h want %h", obs, S_T1);
        end
`endif
        tick();
        tests++;
        if (obs !== S_T2) begin
            fails++; $display("FAIL mem_wait_t2 got %h want %h", obs, S_T2);
        end
        Mem_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset(32'h18000000);
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (obs !== S_T4R || Alu_op !== 5'b00011) begin
            fails++; $display("FAIL areset_pre_t4 got %h alu %b want %h alu 00011",
                              obs, Alu_op, S_T4R);
        end
        #2 Reset_n = 1'b0;
        #1;
        tests++;
        if (obs !== S_NONE || Alu_op !== 5'b0 || Run !== 1'b1) begin
            fails++; $display("FAIL areset_async got %h alu %b run %b want %h alu 00000 run 1",
                              obs, Alu_op, Run, S_NONE);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        tick();
        tests++;
        if (obs !== S_T0) begin
            fails++; $display("FAIL areset_t0 got %h want %h", obs, S_T0);
        end
        tick();
        tests++;
        if (obs !== S_T1) begin
            fails++; $display("FAIL areset_t1 got %h want %h", obs, S_T1);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_stop_t5();
        test_halt_opcode();
        test_stop_nop();
        test_mem_wait();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
